// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial add/subtract sequencer around a single 1-bit full adder

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             c_msb;
    logic             mode;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .A    (sa[0]),
        .B    (sb[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            c_msb <= 1'b0;
            mode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        mode  <= sub;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    // vacated SB bits take the inverted-operand sign fill; they never reach bit 0
                    sb    <= {mode, sb[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c_msb <= carry;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res;
    assign cout      = carry;
    assign ovf       = c_msb ^ carry;
endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - scoreboard bench for serial_add_seq at WIDTH=8

module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    res_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   t;
        res_t         r;
        bb  = ms ? ~mb : mb;
        ci  = ms ? 1'b1 : mc;
        t   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (ma[W-1] == bb[W-1]) && (t[W-1] != ma[W-1]);
        return r;
    endfunction

    // Presents an operand pair until accepted; scrambles the inputs afterwards.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, output bit ok);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // Waits for out_valid, captures the result, and completes one handshake.
    task automatic recv(input logic hold, output res_t got, output int n, output bit ok);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok  = out_valid;
        got = {sum, cout, ovf};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = hold;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        tests++;
        if ({sum, cout, ovf} !== {8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_out: got %h/%b/%b expected 00/0/0", sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic run_directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                input logic tc, input logic ts, input res_t exp);
        bit   ok;
        int   n;
        res_t got;
        res_t want;
        send(ta, tb_v, tc, ts, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_accept: timed out waiting for in_ready", name);
            return;
        end
        sb_q.push_back(exp);
        recv(1'b0, got, n, ok);
        want = sb_q.pop_front();
        tests++;
        if (!ok || n != W) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles (valid=%b) expected %0d", name, n, ok, W);
        end
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s_result: got %h/%b/%b expected %h/%b/%b",
                     name, got.s, got.c, got.o, want.s, want.c, want.o);
        end
    endtask

    task automatic test_add;
        run_directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, '{s: 8'h00, c: 1'b1, o: 1'b0});
        run_directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, '{s: 8'h80, c: 1'b0, o: 1'b1});
        run_directed("add_0f_f0", 8'h0F, 8'hF0, 1'b1, 1'b0, '{s: 8'h00, c: 1'b1, o: 1'b0});
    endtask

    task automatic test_sub;
        run_directed("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, '{s: 8'hFE, c: 1'b0, o: 1'b0});
        run_directed("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, '{s: 8'h7F, c: 1'b1, o: 1'b1});
    endtask

    task automatic test_backpressure;
        bit   ok;
        int   n;
        res_t want;
        out_ready = 1'b0;
        send(8'h3C, 8'h5A, 1'b0, 1'b0, ok);
        sb_q.push_back('{s: 8'h96, c: 1'b0, o: 1'b1});
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        want = sb_q.pop_front();
        tests++;
        if (!ok || !out_valid) begin
            fails++;
            $display("FAIL bp_valid: accept=%b out_valid=%b expected 1 1", ok, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'h11 + 8'(i); b = 8'h22; sub = i[0]; cin = 1'b1;
            @(posedge clk); #1;
            tests++;
            if ({sum, cout, ovf} !== want) begin
                fails++;
                $display("FAIL bp_hold%0d: got %h/%b/%b expected %h/%b/%b",
                         i, sum, cout, ovf, want.s, want.c, want.o);
            end
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_state%0d: in_ready=%b out_valid=%b expected 0 1", i, in_ready, out_valid);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_no_queue: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        send(8'hAA, 8'h55, 1'b0, 1'b0, ok);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b sum=%h expected 1 0 00",
                     in_ready, out_valid, sum);
        end
        run_directed("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, '{s: 8'h46, c: 1'b0, o: 1'b0});
    endtask

    task automatic test_back_to_back;
        bit           ok;
        int           n;
        int           prev_acc;
        res_t         got;
        res_t         want;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, ok);
            if (!ok) begin
                tests++; fails++;
                $display("FAIL b2b_accept%0d: timed out waiting for in_ready", i);
                break;
            end
            sb_q.push_back(model(ra, rb, rc, rs));
            if (i > 0) begin
                tests++;
                if (acc_cyc - prev_acc != W + 2) begin
                    fails++;
                    $display("FAIL b2b_ii%0d: got %0d cycles expected %0d", i, acc_cyc - prev_acc, W + 2);
                end
            end
            prev_acc = acc_cyc;
            recv(1'b1, got, n, ok);
            want = sb_q.pop_front();
            tests++;
            if (!ok || got !== want) begin
                fails++;
                $display("FAIL b2b_result%0d: %h %s %h c%b got %h/%b/%b expected %h/%b/%b",
                         i, ra, rs ? "-" : "+", rb, rc, got.s, got.c, got.o, want.s, want.c, want.o);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial adder/subtractor sequencer. It accepts a WIDTH-bit operand pair over a valid/ready handshake and runs the operation through a single instance of the team's 1-bit `full_adder` cell (ports A, B, Cin, Sum, Cout), LSB first, one bit per clock. The result, carry-out and signed overflow are presented on a held valid/ready output. It trades latency for area and sits wherever a wide adder is too costly.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 2.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- a  input  WIDTH  operand A, sampled on acceptance.
- b  input  WIDTH  operand B, sampled on acceptance.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a−b.
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  final carry; for sub, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after WIDTH bit steps.
  - DONE → IDLE on out_valid && out_ready.
  - No other transitions exist.
- On acceptance:
  - Latch a into shift register SA.
  - Latch b (add) or ~b (sub) into SB.
  - Latch sub into a mode register.
  - Load the carry flip-flop with cin (add) or 1 (sub).
  - Clear the bit counter. Its width is $clog2(WIDTH).
- Each RUN cycle:
  - The full_adder gets A=SA[0], B=SB[0], Cin=carry flip-flop.
  - Sum shifts into the MSB of the result register, which is right-shifting.
  - Cout loads the carry flip-flop.
  - SA and SB shift right by one.
  - The counter increments.
  - On the step where counter == WIDTH−1, capture the carry into bit WIDTH−1 as c_msb, then go to DONE.
- In DONE:
  - sum = result register and cout = carry flip-flop.
  - ovf = c_msb XOR cout.
  - All three are stable while out_valid=1 and out_ready=0.
- Inputs are ignored outside the acceptance cycle. a, b, cin and sub may change freely during RUN and DONE.
- The full_adder instance is the only arithmetic element. No behavioural `+` on operands.
- Reset (rst_n=0 at a rising edge), from any state including mid-RUN:
  - State becomes IDLE and any in-flight operation is discarded.
  - in_ready=1 and out_valid=0 after that edge.
  - sum=0, cout=0, ovf=0.
  - Internal registers are cleared.

## Timing
- Acceptance edge E0 puts the FSM in RUN. Bits 0..WIDTH−1 are processed on edges E1..E_WIDTH.
- out_valid is high after E_WIDTH, i.e. exactly WIDTH cycles after acceptance.
- The output handshake edge returns the FSM to IDLE. in_ready=1 in the following cycle.
- A new operand pair is never accepted in the same cycle as the output handshake.
- Minimum initiation interval with out_ready tied high: WIDTH+2 cycles.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- in_valid asserted in RUN or DONE is neither accepted nor queued. The upstream must hold it.

## Test plan
All scenarios use WIDTH=8.
- Add a=8'hFF, b=8'h01, cin=0, sub=0 -> 8 cycles later out_valid=1 with sum=8'h00, cout=1, ovf=0.
- Add a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Add a=8'h0F, b=8'hF0, cin=1 -> sum=8'h00, cout=1, ovf=0.
- Sub a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. Sub a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with other operands -> sum, cout and ovf stay constant, in_ready=0, nothing is accepted. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: drive rst_n=0 at the edge ending bit step 3 of a=8'hAA+b=8'h55 -> next cycle IDLE, out_valid=0, sum=0. Then run 8'h12+8'h34 -> sum=8'h46, cout=0.
- Throughput: 20 random add/sub operations back-to-back with out_ready=1 -> each result matches the reference model, and consecutive acceptances are exactly 10 cycles apart.
